// File: rtl/tile_pkg.sv
// -----------------------------------------------------------------------------
// tile_pkg
// Shared types and helpers for the tile ROM arbiter slice.
//   TILE_DIM     : tile edge length in texels (16x16 tile)
//   tile_coord_t : 4-bit row/column coordinate inside a tile
//   pixel_t      : 12-bit {R,G,B} texel, 4 bits per channel
//   tile_addr_t  : packed {row, col} pair as presented to the ROM
//   wrap_add     : (base + step) folded back into 0..n-1, without relying on
//                  ID-width overflow so non-power-of-two counts wrap correctly
// -----------------------------------------------------------------------------
package tile_pkg;

   localparam int TILE_DIM = 16;
   localparam int COORD_W  = $clog2(TILE_DIM);
   localparam int PIXEL_W  = 12;

   typedef logic [COORD_W-1:0] tile_coord_t;
   typedef logic [PIXEL_W-1:0] pixel_t;

   typedef struct packed {
      tile_coord_t row;
      tile_coord_t col;
   } tile_addr_t;

   // Modular add for requester indices; base and step are both below n.
   function automatic int wrap_add(input int base, input int step, input int n);
      int sum;
      sum = base + step;
      if (sum >= n) begin
         sum = sum - n;
      end else begin
         sum = sum + 0;
      end
      return sum;
   endfunction

endpackage

// File: rtl/tile_rom_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Searches req starting at ptr and
// wrapping at N-1 -> 0; the first set bit wins. The pointer register itself
// lives in the parent so this block carries no state.
// Ports:
//   req       in  N    request vector
//   ptr       in  IW   index searched first (must be < N)
//   grant     out N    one-hot grant, zero when no request
//   grant_idx out IW   index of the granted requester (0 when none)
//   any_grant out 1    some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter
   import tile_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any_grant
);

   logic [IW-1:0] cand;
   logic          hit;

   // Walk the requesters in priority order from ptr; latch the first hit only.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      cand      = '0;
      hit       = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand = IW'(wrap_add(int'(ptr), k, N));
         hit  = !any_grant && req[cand];
         if (hit) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            any_grant   = 1'b1;
         end else begin
            any_grant   = any_grant;
         end
      end
   end

endmodule

// File: rtl/tile_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tile_rom_arbiter
// Shares one combinational tile ROM among N_REQ pixel requesters. One lookup
// is accepted per clock (round-robin), the ROM address is registered in the
// address stage, the ROM data is registered in the data stage, and the result
// is returned with a one-hot tag exactly two clocks after acceptance.
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous, active-high reset
//   req_valid  in   N_REQ      per-requester lookup request
//   req_row    in   4*N_REQ    requester i row in bits [4i+3:4i]
//   req_col    in   4*N_REQ    requester i col in bits [4i+3:4i]
//   req_ready  out  N_REQ      one-hot grant (combinational), 0 during reset
//   rom_row    out  4          registered ROM row address
//   rom_col    out  4          registered ROM col address
//   rom_rgb    in   12         ROM data, combinational from rom_row/rom_col
//   rsp_valid  out  N_REQ      one-hot, single-cycle response tag
//   rsp_rgb    out  12         pixel data qualifying rsp_valid
//   busy       out  1          a lookup is in either pipeline stage
// -----------------------------------------------------------------------------
module tile_rom_arbiter
   import tile_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [4*N_REQ-1:0]   req_row,
   input  logic [4*N_REQ-1:0]   req_col,
   output logic [N_REQ-1:0]     req_ready,
   output tile_coord_t          rom_row,
   output tile_coord_t          rom_col,
   input  pixel_t               rom_rgb,
   output logic [N_REQ-1:0]     rsp_valid,
   output pixel_t               rsp_rgb,
   output logic                 busy
);

   // Arbitration state and combinational results
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  next_ptr;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             any_grant;
   logic             accept;
   tile_coord_t      sel_row;
   tile_coord_t      sel_col;

   // Pipeline registers. The one-hot rsp_valid register doubles as the
   // stage-2 requester tag, so no separate encoded stage-2 id is kept.
   logic             s1_valid;
   logic [ID_W-1:0]  s1_id;
   logic             s2_valid;
   logic [N_REQ-1:0] rsp_next;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Grant qualification: nothing is accepted while reset is asserted.
   always_comb begin
      req_ready = '0;
      accept    = 1'b0;
      if (reset) begin
         req_ready = '0;
         accept    = 1'b0;
      end else begin
         req_ready = grant;
         accept    = any_grant;
      end
   end

   // Pointer advance with an explicit wrap so N_REQ need not be a power of two.
   always_comb begin
      next_ptr = '0;
      if (grant_idx == ID_W'(N_REQ - 1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = grant_idx + ID_W'(1);
      end
   end

   // Select the granted requester's coordinates from the packed input buses.
   always_comb begin
      sel_row = '0;
      sel_col = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_row = (grant_idx == ID_W'(i)) ? req_row[4*i +: 4] : sel_row;
         sel_col = (grant_idx == ID_W'(i)) ? req_col[4*i +: 4] : sel_col;
      end
   end

   // Decode the stage-1 tag into the one-hot response vector for next cycle.
   always_comb begin
      rsp_next = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rsp_next[i] = s1_valid && (s1_id == ID_W'(i));
      end
   end

   // Round-robin pointer: moves past the winner, holds when nobody is granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= next_ptr;
      end else begin
         rr_ptr <= rr_ptr;
      end
   end

   // Address stage: capture the accepted lookup. The ROM address holds on idle
   // cycles so the ROM inputs do not toggle needlessly.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         rom_row  <= '0;
         rom_col  <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_id    <= grant_idx;
         rom_row  <= sel_row;
         rom_col  <= sel_col;
      end else begin
         s1_valid <= 1'b0;
         s1_id    <= s1_id;
         rom_row  <= rom_row;
         rom_col  <= rom_col;
      end
   end

   // Data stage: register ROM data and the tag; data holds when no lookup.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid  <= 1'b0;
         rsp_valid <= '0;
         rsp_rgb   <= '0;
      end else begin
         s2_valid  <= s1_valid;
         rsp_valid <= rsp_next;
         if (s1_valid) begin
            rsp_rgb <= rom_rgb;
         end else begin
            rsp_rgb <= rsp_rgb;
         end
      end
   end

   assign busy = s1_valid | s2_valid;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tile_rom_arbiter
// Directed stimulus with a response scoreboard. The driver pushes the
// hand-computed response (tag, pixel, arrival cycle) for every expected
// grant; an independent monitor pops and compares whenever rsp_valid is set.
// A small wall-tile ROM model sits on the rom_* ports.
// -----------------------------------------------------------------------------
module tb_tile_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = 4'b0000;
   logic [15:0] req_row = 16'h0000;
   logic [15:0] req_col = 16'h0000;
   logic [3:0]  req_ready;
   logic [3:0]  rom_row;
   logic [3:0]  rom_col;
   logic [11:0] rom_rgb;
   logic [3:0]  rsp_valid;
   logic [11:0] rsp_rgb;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      logic [3:0]  id;
      logic [11:0] rgb;
      int          cyc;
   } sb_entry_t;

   sb_entry_t sb[$];

   tile_rom_arbiter #(.N_REQ(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_row   (req_row),
      .req_col   (req_col),
      .req_ready (req_ready),
      .rom_row   (rom_row),
      .rom_col   (rom_col),
      .rom_rgb   (rom_rgb),
      .rsp_valid (rsp_valid),
      .rsp_rgb   (rsp_rgb),
      .busy      (busy)
   );

   // Wall tile ROM model: known texels, everything else {row, col, row^col}.
   function automatic logic [11:0] rom_model(input logic [3:0] r, input logic [3:0] c);
      logic [7:0] a;
      a = {r, c};
      case (a)
         8'h00:   return 12'h666;
         8'h31:   return 12'hA9A;
         8'hFF:   return 12'h111;
         8'h62:   return 12'hBBB;
         8'h0A:   return 12'h000;
         default: return {r, c, r ^ c};
      endcase
   endfunction

   assign rom_rgb = rom_model(rom_row, rom_col);

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One stimulus cycle: drive after the falling edge, check the combinational
   // grant, and queue the expected response if a grant is expected.
   task automatic step(input bit rst, input logic [3:0] v, input logic [15:0] rows,
                       input logic [15:0] cols, input logic [3:0] exp_ready,
                       input bit push, input logic [11:0] exp_rgb, input int exp_busy);
      sb_entry_t e;
      @(negedge clk);
      reset     = rst;
      req_valid = v;
      req_row   = rows;
      req_col   = cols;
      #1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_busy >= 0) check("busy", 32'(busy), 32'(exp_busy));
      if (push) begin
         e.id  = exp_ready;
         e.rgb = exp_rgb;
         e.cyc = cyc + 2;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int exp_busy);
      step(1'b0, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b0, 12'h000, exp_busy);
   endtask

   // Response monitor: every rsp_valid pulse must match the head of the queue
   // at the expected cycle; an overdue head entry is a missing response.
   always @(negedge clk) begin : monitor
      sb_entry_t e;
      if (mon_en) begin
         if (rsp_valid !== 4'b0000) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'(4'b0000));
            end else begin
               e = sb.pop_front();
               check("rsp_id", 32'(rsp_valid), 32'(e.id));
               check("rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
               check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check("rsp_missing", 32'(rsp_valid), 32'(e.id));
         end
      end
   end

   initial begin
      // 1: reset held three clocks with every requester valid
      for (int i = 0; i < 3; i++)
         step(1'b1, 4'b1111, 16'h06F3, 16'hA2F1, 4'b0000, 1'b0, 12'h000, -1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'(4'b0000));
      check("reset_busy", 32'(busy), 32'(1'b0));
      check("reset_rom_row", 32'(rom_row), 32'(4'h0));
      check("reset_rom_col", 32'(rom_col), 32'(4'h0));
      mon_en = 1'b1;

      // 2: single request from requester 0 at (0,0)
      step(1'b0, 4'b0001, 16'h0000, 16'h0000, 4'b0001, 1'b1, 12'h666, 0);
      idle(1);
      idle(1);
      idle(0);

      // 3: all four valid continuously, starting from a fresh pointer
      step(1'b1, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b0, 12'h000, -1);
      for (int r = 0; r < 2; r++) begin
         step(1'b0, 4'b1111, 16'h06F3, 16'hA2F1, 4'b0001, 1'b1, 12'hA9A, -1);
         step(1'b0, 4'b1111, 16'h06F3, 16'hA2F1, 4'b0010, 1'b1, 12'h111, -1);
         step(1'b0, 4'b1111, 16'h06F3, 16'hA2F1, 4'b0100, 1'b1, 12'hBBB, -1);
         step(1'b0, 4'b1111, 16'h06F3, 16'hA2F1, 4'b1000, 1'b1, 12'h000, 1);
      end
      idle(1);
      idle(1);

      // 4: req2 alone, then req0+req3 -> 3 wins, then 0
      step(1'b0, 4'b0100, 16'h0100, 16'h0200, 4'b0100, 1'b1, 12'h123, 0);
      step(1'b0, 4'b1001, 16'h4008, 16'h5003, 4'b1000, 1'b1, 12'h451, 1);
      step(1'b0, 4'b0001, 16'h4008, 16'h5003, 4'b0001, 1'b1, 12'h83B, 1);
      idle(1);
      idle(1);
      idle(0);

      // 5: reset the cycle after an accept; that lookup must vanish
      step(1'b0, 4'b0001, 16'h0003, 16'h0001, 4'b0001, 1'b0, 12'h000, 0);
      step(1'b1, 4'b1010, 16'h06F3, 16'hA2F1, 4'b0000, 1'b0, 12'h000, -1);
      step(1'b0, 4'b1010, 16'h06F3, 16'hA2F1, 4'b0010, 1'b1, 12'h111, 0);
      step(1'b0, 4'b1000, 16'h06F3, 16'hA2F1, 4'b1000, 1'b1, 12'h000, 1);
      idle(1);
      idle(1);
      idle(0);

      // 6: req1 on alternate cycles; ROM address holds while idle
      for (int r = 0; r < 3; r++) begin
         step(1'b0, 4'b0010, 16'h0020, 16'h0070, 4'b0010, 1'b1, 12'h275, -1);
         idle(1);
         check("hold_rom_row", 32'(rom_row), 32'(4'h2));
         check("hold_rom_col", 32'(rom_col), 32'(4'h7));
      end
      idle(1);
      idle(0);
      check("idle_rom_row", 32'(rom_row), 32'(4'h2));

      for (int i = 0; i < 4; i++) idle(0);
      check("scoreboard_drained", 32'(sb.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
